hostsystem_timer_sequencer: RTL and testbench

Avalon-MM master controller that owns the HostSystem interval-timer slave and shares it between `N` requesters. It arbitrates requests round-robin and programs period and control for the winner. It then waits for the timer `irq`, clears the timer status, and reports each timeout to the owner. It sits between the Nios II peripheral requesters and the timer's `s1` slave; nothing else writes the timer.

---
 rtl/hostsystem_timer_pkg.sv | 37 +++
 rtl/hostsystem_rr_arbiter.sv | 37 +++
 rtl/hostsystem_timer_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_hostsystem_timer_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hostsystem_timer_pkg.sv
// Shared definitions for the interval-timer sequencer: timer register map,
// control-word bit positions and the sequencer state encoding.
package hostsystem_timer_pkg;

    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTL,
        ST_WAIT,
        ST_CLR,
        ST_STOP,
        ST_RELEASE
    } state_e;

    function automatic logic [15:0] ctl_word(input logic stop, input logic start,
                                             input logic cont, input logic ito);
        logic [15:0] w;
        w            = '0;
        w[CTL_STOP]  = stop;
        w[CTL_START] = start;
        w[CTL_CONT]  = cont;
        w[CTL_ITO]   = ito;
        return w;
    endfunction

endpackage

// File: rtl/hostsystem_rr_arbiter.sv
// Round-robin pick: first requester at or after i_ptr wins. Combinational, zero latency.
// No backpressure; the caller owns the pointer register and decides when to advance it.
module hostsystem_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic [PW-1:0] o_ptr_nxt,
    output logic          o_vld
);

    int   w_j;
    logic w_found;

    always_comb begin
        o_gnt     = '0;
        o_idx     = '0;
        o_ptr_nxt = i_ptr;
        w_found   = 1'b0;
        w_j       = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = PW'(w_j);
                o_ptr_nxt  = PW'((w_j + 1) % N);
            end
        end
    end

    assign o_vld = |i_req;

endmodule

// File: rtl/hostsystem_timer_sequencer.sv
// Shares one Avalon-MM interval timer among N requesters: arbitrate, program, relay timeouts.
// Grant one cycle after req in IDLE; 3 back-to-back writes; done 1 cycle after irq; no waitrequest.
module hostsystem_timer_sequencer
    import hostsystem_timer_pkg::*;
#(
    parameter int N          = 4,
    parameter int MIN_PERIOD = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic [32*N-1:0] period,
    input  logic [N-1:0]    continuous,
    input  logic [N-1:0]    cancel,
    output logic [N-1:0]    grant,
    output logic [N-1:0]    done,
    output logic            busy,
    output logic [2:0]      tmr_address,
    output logic            tmr_chipselect,
    output logic            tmr_write_n,
    output logic [15:0]     tmr_writedata,
    input  logic            tmr_irq
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_e        r_state, w_state_nxt;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_arb_idx, w_arb_ptr_nxt;
    logic [N-1:0]  w_arb_gnt;
    logic          w_arb_vld;

    logic [N-1:0]  r_grant, r_done, w_grant_nxt, w_done_nxt;
    logic          r_busy;
    logic [31:0]   r_load, w_load_new, w_per_sel;
    logic          r_cont;
    logic          r_cxl, w_cxl_nxt, w_cancel;

    logic          r_cs, r_wn, w_cs_nxt;
    logic [2:0]    r_addr, w_addr_nxt;
    logic [15:0]   r_wdat, w_wdat_nxt;

    hostsystem_rr_arbiter #(.N(N), .PW(PW)) u_arb (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_arb_gnt),
        .o_idx     (w_arb_idx),
        .o_ptr_nxt (w_arb_ptr_nxt),
        .o_vld     (w_arb_vld)
    );

    // The timer reloads with the programmed value, so program P-1 for a P-cycle period.
    assign w_per_sel  = period[32*int'(w_arb_idx) +: 32];
    assign w_load_new = ((w_per_sel < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : w_per_sel) - 32'd1;
    assign w_cancel   = |(cancel & r_grant);

    always_comb begin
        w_state_nxt = r_state;
        w_cxl_nxt   = r_cxl;
        case (r_state)
            ST_IDLE: begin
                w_cxl_nxt = 1'b0;
                if (w_arb_vld) w_state_nxt = ST_WR_PL;
            end
            ST_WR_PL: begin
                if (w_cancel) w_cxl_nxt = 1'b1;
                w_state_nxt = ST_WR_PH;
            end
            ST_WR_PH: begin
                if (w_cancel) w_cxl_nxt = 1'b1;
                w_state_nxt = ST_WR_CTL;
            end
            ST_WR_CTL: begin
                if (r_cxl || w_cancel) begin
                    w_cxl_nxt   = 1'b1;
                    w_state_nxt = ST_STOP;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_cancel) begin
                    w_cxl_nxt   = 1'b1;
                    w_state_nxt = ST_STOP;
                end else if (tmr_irq) begin
                    w_state_nxt = ST_CLR;
                end
            end
            // CLR doubles as the final status write of a stop sequence (r_cxl set).
            ST_CLR: begin
                if (!r_cxl && r_cont) w_state_nxt = ST_WAIT;
                else                  w_state_nxt = ST_RELEASE;
            end
            ST_STOP:    w_state_nxt = ST_CLR;
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus and status outputs are registered, so they are decoded from the next state.
    always_comb begin
        w_cs_nxt   = 1'b0;
        w_addr_nxt = TMR_STATUS;
        w_wdat_nxt = '0;
        case (w_state_nxt)
            ST_WR_PL: begin
                w_cs_nxt   = 1'b1;
                w_addr_nxt = TMR_PERIODL;
                w_wdat_nxt = w_load_new[15:0];
            end
            ST_WR_PH: begin
                w_cs_nxt   = 1'b1;
                w_addr_nxt = TMR_PERIODH;
                w_wdat_nxt = r_load[31:16];
            end
            ST_WR_CTL: begin
                w_cs_nxt   = 1'b1;
                w_addr_nxt = TMR_CONTROL;
                w_wdat_nxt = ctl_word(1'b0, 1'b1, r_cont, 1'b1);
            end
            ST_CLR: begin
                w_cs_nxt   = 1'b1;
                w_addr_nxt = TMR_STATUS;
                w_wdat_nxt = '0;
            end
            ST_STOP: begin
                w_cs_nxt   = 1'b1;
                w_addr_nxt = TMR_CONTROL;
                w_wdat_nxt = ctl_word(1'b1, 1'b0, 1'b0, 1'b0);
            end
            default: begin
                w_cs_nxt   = 1'b0;
                w_addr_nxt = TMR_STATUS;
                w_wdat_nxt = '0;
            end
        endcase

        w_grant_nxt = r_grant;
        if (r_state == ST_IDLE && w_arb_vld) w_grant_nxt = w_arb_gnt;
        if (w_state_nxt == ST_RELEASE)        w_grant_nxt = '0;

        w_done_nxt = (w_state_nxt == ST_CLR && !w_cxl_nxt) ? r_grant : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_load  <= '0;
            r_cont  <= 1'b0;
            r_cxl   <= 1'b0;
            r_cs    <= 1'b0;
            r_wn    <= 1'b1;
            r_addr  <= TMR_STATUS;
            r_wdat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cxl   <= w_cxl_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_cs    <= w_cs_nxt;
            r_wn    <= ~w_cs_nxt;
            r_addr  <= w_addr_nxt;
            r_wdat  <= w_wdat_nxt;
            if (r_state == ST_IDLE && w_arb_vld) begin
                r_ptr  <= w_arb_ptr_nxt;
                r_load <= w_load_new;
                r_cont <= continuous[w_arb_idx];
            end
        end
    end

    assign grant          = r_grant;
    assign done           = r_done;
    assign busy           = r_busy;
    assign tmr_chipselect = r_cs;
    assign tmr_write_n    = r_wn;
    assign tmr_address    = r_addr;
    assign tmr_writedata  = r_wdat;

endmodule

// File: tb/tb_hostsystem_timer_sequencer.sv
// Bench for hostsystem_timer_sequencer: behavioural interval-timer slave, write/done logs,
// and a transaction-level model (round-robin pointer, clamp, expected write list).
module tb_hostsystem_timer_sequencer;

    localparam int N      = 4;
    localparam int MIN_P  = 4;
    localparam int BUDGET = 20000;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req, continuous, cancel;
    logic [32*N-1:0] period_bus;
    logic [N-1:0]    grant, done;
    logic            busy;
    logic [2:0]      tmr_address;
    logic            tmr_chipselect, tmr_write_n;
    logic [15:0]     tmr_writedata;
    logic            tmr_irq;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int m_ptr = 0;

    int wq_a[$], wq_d[$], wq_c[$];
    int dq_v[$], dq_c[$];

    hostsystem_timer_sequencer #(.N(N), .MIN_PERIOD(MIN_P)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .period         (period_bus),
        .continuous     (continuous),
        .cancel         (cancel),
        .grant          (grant),
        .done           (done),
        .busy           (busy),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Interval timer slave: counts L..0 then reloads; timeout reaches irq two edges after zero.
    logic [15:0] t_pl, t_ph;
    logic [31:0] t_cnt;
    logic        t_run, t_cont, t_ito, t_zero, t_to;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_pl <= '0; t_ph <= '0; t_cnt <= '0;
            t_run <= 1'b0; t_cont <= 1'b0; t_ito <= 1'b0; t_zero <= 1'b0; t_to <= 1'b0;
        end else begin
            t_zero <= 1'b0;
            if (t_run) begin
                if (t_cnt == 0) begin
                    t_zero <= 1'b1;
                    t_cnt  <= {t_ph, t_pl};
                    if (!t_cont) t_run <= 1'b0;
                end else begin
                    t_cnt <= t_cnt - 1;
                end
            end
            if (tmr_chipselect && !tmr_write_n) begin
                case (tmr_address)
                    3'd1: begin
                        t_cont <= tmr_writedata[1];
                        t_ito  <= tmr_writedata[0];
                        if (tmr_writedata[3]) t_run <= 1'b0;
                        if (tmr_writedata[2]) begin
                            t_run <= 1'b1;
                            t_cnt <= {t_ph, t_pl};
                        end
                    end
                    3'd2: t_pl <= tmr_writedata;
                    3'd3: t_ph <= tmr_writedata;
                    default: ;
                endcase
            end
            if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) t_to <= 1'b0;
            else if (t_zero)                                            t_to <= 1'b1;
        end
    end
    assign tmr_irq = t_to & t_ito;

    always @(negedge clk) begin
        if (reset_n) begin
            if (tmr_chipselect && !tmr_write_n) begin
                wq_a.push_back(int'(tmr_address));
                wq_d.push_back(int'(tmr_writedata));
                wq_c.push_back(cyc);
            end
            if (done != 0) begin
                dq_v.push_back(int'(done));
                dq_c.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++)
            if (mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return 0;
    endfunction

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_cs"},   tmr_chipselect, 0);
        chk({tag, "_wn"},   tmr_write_n, 1);
        chk({tag, "_addr"}, tmr_address, 0);
        chk({tag, "_wdat"}, tmr_writedata, 0);
    endtask

    // mode 0: natural end (one-shot timeout, or ndone timeouts then cancel); 1: cancel in WR_PH;
    // 2: cancel on the cycle irq is seen; 3: cancel on the first WAIT cycle.
    task automatic do_txn(input logic [N-1:0] mask, input logic [N-1:0] contv,
                          input int mode, input int ndone);
        int w, lat, n, exp_done;
        logic [31:0] p, l;
        logic cancelled;
        int ea[$], ed[$];
        w = rr_pick(mask);
        m_ptr = (w + 1) % N;
        p = period_bus[32*w +: 32];
        if (p < MIN_P) p = MIN_P;
        l = p - 1;
        wq_a.delete(); wq_d.delete(); wq_c.delete(); dq_v.delete(); dq_c.delete();

        @(negedge clk);
        continuous = contv;
        req = mask;
        lat = 0;
        do begin @(negedge clk); lat++; end while (grant == 0 && lat < 20);
        chk("grant_latency", lat, 1);
        chk("grant_onehot", grant, 32'(1) << w);
        req = '0;

        case (mode)
            1: begin
                @(negedge clk); cancel[w] = 1'b1;
                @(negedge clk); cancel = '0;
            end
            2: begin
                n = 0;
                while (!tmr_irq && n < BUDGET) begin @(negedge clk); n++; end
                chk("irq_seen", n < BUDGET, 1);
                cancel[w] = 1'b1;
            end
            3: begin
                repeat (3) @(negedge clk);
                cancel[w] = 1'b1;
            end
            default: begin
                if (contv[w]) begin
                    n = 0;
                    while (dq_v.size() < ndone && n < BUDGET) begin @(negedge clk); n++; end
                    chk("cont_dones_seen", n < BUDGET, 1);
                    cancel[w] = 1'b1;
                end else begin
                    cancel = ~(N'(1) << w);
                end
            end
        endcase

        n = 0;
        while (grant != 0 && n < BUDGET) begin @(negedge clk); n++; end
        chk("release_in_budget", n < BUDGET, 1);
        cancel = '0;
        repeat (6) @(negedge clk);
        chk("busy_after", busy, 0);
        chk_idle_bus("idle_after");

        exp_done  = (mode == 0) ? (contv[w] ? ndone : 1) : 0;
        cancelled = (mode != 0) || contv[w];
        ea.push_back(2); ed.push_back(int'(l[15:0]));
        ea.push_back(3); ed.push_back(int'(l[31:16]));
        ea.push_back(1); ed.push_back(contv[w] ? 7 : 5);
        for (int i = 0; i < exp_done; i++) begin ea.push_back(0); ed.push_back(0); end
        if (cancelled) begin
            ea.push_back(1); ed.push_back(8);
            ea.push_back(0); ed.push_back(0);
        end

        chk("write_count", wq_a.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wq_a.size(); i++) begin
            chk($sformatf("wr%0d_addr", i), wq_a[i], ea[i]);
            chk($sformatf("wr%0d_data", i), wq_d[i], ed[i]);
        end
        if (wq_c.size() >= 3) chk("prog_back_to_back", wq_c[2] - wq_c[0], 2);
        chk("done_count", dq_v.size(), exp_done);
        for (int i = 0; i < dq_v.size(); i++) begin
            chk($sformatf("done%0d_owner", i), dq_v[i], 32'(1) << w);
            if (i == 0 && wq_c.size() >= 3) chk("done0_latency", dq_c[0] - wq_c[2], p + 3);
            if (i > 0) chk($sformatf("done%0d_spacing", i), dq_c[i] - dq_c[i-1], p);
            if (3 + i < wq_c.size()) chk($sformatf("done%0d_with_status", i), dq_c[i], wq_c[3+i]);
        end
    endtask

    initial begin
        int n, w;
        reset_n    = 1'b0;
        req        = '0;
        continuous = '0;
        cancel     = '0;
        period_bus = '0;
        #23;
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk_idle_bus("rst");
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // One-shot on requester 1, period 100
        period_bus[32*1 +: 32] = 100;
        do_txn(4'b0010, 4'b0000, 0, 0);
        // Continuous on requester 0, period 1000, five timeouts then cancel
        period_bus[32*0 +: 32] = 1000;
        do_txn(4'b0001, 4'b0001, 0, 5);
        // Cancel in WAIT, during WR_PH, and together with irq
        period_bus[32*2 +: 32] = 20;
        do_txn(4'b0100, 4'b0000, 3, 0);
        period_bus[32*3 +: 32] = 20;
        do_txn(4'b1000, 4'b0000, 1, 0);
        period_bus[32*1 +: 32] = 10;
        do_txn(4'b0010, 4'b0000, 2, 0);
        // Period clamp and a wide period
        period_bus[32*2 +: 32] = 0;
        do_txn(4'b0100, 4'b0000, 0, 0);
        period_bus[32*3 +: 32] = 3;
        do_txn(4'b1000, 4'b0000, 0, 0);
        period_bus[32*0 +: 32] = 32'h0001_2345;
        do_txn(4'b0001, 4'b0000, 3, 0);

        // Reset in WAIT after granting requester 1 (pointer would otherwise be 2)
        period_bus[32*1 +: 32] = 200;
        @(negedge clk); req = 4'b0010; continuous = '0;
        n = 0;
        while (grant == 0 && n < 20) begin @(negedge clk); n++; end
        req = '0;
        repeat (10) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        @(posedge clk); #2; reset_n = 1'b0; #1;
        chk("arst_grant", grant, 0);
        chk("arst_done", done, 0);
        chk("arst_busy", busy, 0);
        chk_idle_bus("arst");
        m_ptr = 0;
        @(negedge clk); reset_n = 1'b1;

        // Round-robin with all requests held, one-shot period 10
        for (int i = 0; i < N; i++) period_bus[32*i +: 32] = 10;
        @(negedge clk); req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            w = rr_pick(4'b1111);
            m_ptr = (w + 1) % N;
            n = 0;
            while (grant == 0 && n < 200) begin @(negedge clk); n++; end
            chk($sformatf("rr_grant%0d", g), grant, 32'(1) << w);
            n = 0;
            while (grant != 0 && n < 200) begin @(negedge clk); n++; end
            chk($sformatf("rr_release%0d", g), n < 200, 1);
        end
        req = '0;
        repeat (4) @(negedge clk);
        chk("rr_busy_after", busy, 0);

        // Randomized transactions
        for (int t = 0; t < 10; t++) begin
            logic [N-1:0] mask, contv;
            mask  = N'($urandom_range(1, (1 << N) - 1));
            contv = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) period_bus[32*i +: 32] = $urandom_range(0, 30);
            do_txn(mask, contv, $urandom_range(0, 3), $urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
